otter_fetch_buffer: RTL and testbench
=====================================

// Module: otter_fetch_buffer
// PURPOSE
//  Instruction-fetch stage of the pipelined OTTER: owns the fetch PC, issues reads to the
//  synchronous instruction port of OTTER_mem_byte (1-cycle read latency), and buffers
//  {pc, ir} pairs in a small queue.
//  Presents them to the decode stage with a valid/ready handshake. Decode stalls become
//  backpressure instead of register enables. Taken branch/jump/trap redirects flush the queue
//  and any in-flight read.
// PARAMETERS
//  DEPTH     4        queue entries; power of two, >= 2
//  RESET_PC  32'h0    first fetch address after reset
// PORTS
//  CLK          in   1          clock; all state on rising edge
//  RST_N        in   1          async active-low reset
//  FETCH_ADDR   out  32         instruction read address (to MEM_ADDR1)
//  FETCH_RD     out  1          read request this cycle (to MEM_READ1)
//  FETCH_DATA   in   32         read data, valid the cycle after FETCH_RD (MEM_DOUT1)
//  REDIRECT     in   1          flush + restart fetch at REDIRECT_PC (from decode/CSR)
//  REDIRECT_PC  in   32         new PC; bits [1:0] ignored, treated as 0
//  DEC_VALID    out  1          DEC_IR/DEC_PC hold a valid instruction
//  DEC_READY    in   1          decode accepts head entry when DEC_VALID && DEC_READY
//  DEC_IR       out  32         head instruction; NOP (32'h00000013) when !DEC_VALID
//  DEC_PC       out  32         head PC; 0 when !DEC_VALID
//  COUNT        out  clog2(DEPTH)+1  occupied entries (debug/verification)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, inflight=0, DEC_VALID=0, DEC_IR=NOP, DEC_PC=0,
//   FETCH_RD=0 while RST_N low. Reset is honoured mid-operation and discards everything.
//  Issue: FETCH_RD=1 when credit = COUNT + inflight - pop < DEPTH, where pop = DEC_VALID&&DEC_READY.
//   When issued: FETCH_ADDR=fetch_pc, inflight<=1, fetch_pc<=fetch_pc+4 (mod 2^32 wrap).
//  Response: if inflight && no REDIRECT this cycle, FETCH_DATA is pushed with its pc.
//   inflight_pc is captured at issue.
//  Latency: issue cycle t -> entry in queue end of t+1 -> DEC_VALID in t+2.
//   Steady state with DEC_READY=1: one instruction per cycle, no bubbles.
//  Full: credit prevents any push into a full queue. A push and a pop in the same cycle leave
//   COUNT unchanged. That holds at COUNT==DEPTH with pop too.
//  Empty: DEC_VALID=0; a response arriving the same cycle is not bypassed (visible next cycle).
//  REDIRECT (highest priority over push/pop):
//   - Same cycle: FETCH_RD=1, FETCH_ADDR={REDIRECT_PC[31:2],2'b00}, combinational.
//   - Clock edge: queue cleared (ptrs/COUNT=0), fetch_pc<=REDIRECT_PC+4, inflight<=1 (new request).
//   - Stale in-flight response that returns that cycle is dropped.
//   - A pop coinciding with REDIRECT is still an accepted handshake for decode.
//   - Next cycle: DEC_VALID=0; following cycle: DEC_PC=REDIRECT_PC.
//   - Back-to-back redirects: the last one wins.
//  Pointers: rd/wr ptrs clog2(DEPTH) bits, wrap naturally; COUNT tracked separately.
//  DEC_IR/DEC_PC driven from registered head entry; no combinational path DEC_READY->DEC_*.
//   Combinational paths that do exist: DEC_READY->FETCH_RD and REDIRECT->FETCH_*.
// STRUCTURE
//  Package otter_fetch_pkg:
//   - typedef struct packed {logic [31:0] pc; logic [31:0] ir;} fetch_entry_t
//   - localparam OTTER_NOP = 32'h00000013
//   - localparam INSTR_BYTES = 4
//  Sub-module otter_fetch_fifo: generic DEPTH x fetch_entry_t storage.
//   - Ports: push, pop, flush, head, count.
//   - Async active-low reset on ptrs/count only; the storage array itself is not reset.
//  Top: fetch_pc/inflight registers, credit/issue logic, redirect muxing, output masking.
// TESTING
//  1 Release RST_N at cycle 0, DEC_READY=1 -> FETCH_ADDR=0 cycle 0; DEC_VALID cycle 2,
//    DEC_PC=0. Then 4, 8, 0xC on consecutive cycles.
//  2 DEC_READY=0 for 12 cycles -> COUNT saturates at 4; FETCH_RD=0 once credit exhausted.
//    Raise DEC_READY -> PCs continue in order, no loss, no duplicate.
//  3 Queue full + inflight, REDIRECT=1 with REDIRECT_PC=0x100 -> FETCH_ADDR=0x100 same cycle.
//    Next cycle DEC_VALID=0, COUNT=0; then DEC_PC=0x100, 0x104, ...; no stale PC appears.
//  4 REDIRECT_PC=0x203 -> fetch at 0x200. REDIRECT on consecutive cycles to 0x40 then 0x80
//    -> only 0x80 stream observed.
//  5 DEC_READY toggling 1/0 each cycle for 40 cycles -> every PC delivered exactly once.
//    COUNT never >4; FETCH_RD never asserts with credit==DEPTH.
//  6 Assert RST_N low mid-stream with COUNT=3 -> DEC_VALID=0, DEC_IR=NOP immediately (async).
//    After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch buffer.
//   fetch_entry_t : one queued {pc, ir} pair handed to decode
//   OTTER_NOP     : instruction presented to decode when nothing is valid (addi x0,x0,0)
//   INSTR_BYTES   : PC increment per sequential fetch
//   align_pc      : clears the byte-offset bits of a fetch address
package otter_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  localparam logic [31:0] OTTER_NOP   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/otter_fetch_fifo.sv
// Generic DEPTH-entry queue of fetch_entry_t for the fetch buffer.
//   clk, rst_n : clock, async active-low reset (pointers and count only)
//   push       : write push_data at the tail (ignored when full unless popping)
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored when empty)
//   flush      : clear the queue; overrides push and pop
//   head       : entry at the read pointer (undefined contents when count == 0)
//   count      : occupied entries, 0..DEPTH
module otter_fetch_fifo
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop frees the slot in the same cycle, so push at full is legal alongside it.
    do_push  = push && ((count_q != FULL_C) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/otter_fetch_buffer.sv
// Instruction-fetch stage of the pipelined OTTER.
// Owns the fetch PC, issues reads to the 1-cycle-latency instruction port of
// OTTER_mem_byte, and queues {pc, ir} pairs for decode behind a valid/ready handshake.
//   CLK, RST_N    : clock, async active-low reset
//   FETCH_ADDR/RD : instruction read request (MEM_ADDR1 / MEM_READ1)
//   FETCH_DATA    : read data, valid the cycle after FETCH_RD (MEM_DOUT1)
//   REDIRECT(_PC) : flush queue and in-flight read, restart fetch at REDIRECT_PC
//   DEC_VALID/READY, DEC_IR, DEC_PC : head entry to decode (NOP / 0 when not valid)
//   COUNT         : occupied queue entries
module otter_fetch_buffer
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  output logic [31:0]             FETCH_ADDR,
  output logic                    FETCH_RD,
  input  logic [31:0]             FETCH_DATA,
  input  logic                    REDIRECT,
  input  logic [31:0]             REDIRECT_PC,
  output logic                    DEC_VALID,
  input  logic                    DEC_READY,
  output logic [31:0]             DEC_IR,
  output logic [31:0]             DEC_PC,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;

  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic          q_push, q_pop, head_valid;
  logic [CW:0]   credit;
  logic          credit_ok;
  logic [31:0]   redirect_pc_aligned;

  otter_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (REDIRECT),
    .head      (q_head),
    .count     (q_count)
  );

  always_comb begin
    head_valid          = (q_count != '0);
    q_pop               = head_valid && DEC_READY;
    // Slots already spoken for: queued entries plus the read in flight, minus the
    // one decode takes this cycle. Never exceeds DEPTH, so no underflow/overflow.
    credit              = {1'b0, q_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, q_pop};
    credit_ok           = (credit < DEPTH_C);
    redirect_pc_aligned = align_pc(REDIRECT_PC);

    // A response arriving alongside a redirect belongs to the abandoned stream.
    q_push         = inflight_q && !REDIRECT;
    q_push_data.pc = inflight_pc_q;
    q_push_data.ir = FETCH_DATA;

    FETCH_RD   = RST_N && (REDIRECT || credit_ok);
    FETCH_ADDR = REDIRECT ? redirect_pc_aligned : fetch_pc_q;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (REDIRECT) begin
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_pc_aligned;
      fetch_pc_d    = redirect_pc_aligned + 32'(INSTR_BYTES);
    end else if (credit_ok) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  // Decode sees only registered queue state, never a same-cycle response.
  assign DEC_VALID = head_valid;
  assign DEC_IR    = head_valid ? q_head.ir : OTTER_NOP;
  assign DEC_PC    = head_valid ? q_head.pc : '0;
  assign COUNT     = q_count;

endmodule

// File: tb/tb_otter_fetch_buffer.sv
module tb_otter_fetch_buffer;
  import otter_fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] FETCH_ADDR;
  logic        FETCH_RD;
  logic [31:0] FETCH_DATA = '0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        DEC_VALID;
  logic        DEC_READY = 1'b0;
  logic [31:0] DEC_IR;
  logic [31:0] DEC_PC;
  logic [2:0]  COUNT;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;

  otter_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST_N(RST_N), .FETCH_ADDR(FETCH_ADDR), .FETCH_RD(FETCH_RD),
    .FETCH_DATA(FETCH_DATA), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY), .DEC_IR(DEC_IR),
    .DEC_PC(DEC_PC), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ir_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge CLK) if (FETCH_RD) FETCH_DATA <= ir_of(FETCH_ADDR);

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; DEC_READY = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = '0;
    tick; tick;
    n_cmp++; if (FETCH_RD !== 1'b0) begin n_err++; $display("FAIL reset_fetch_rd got %0b want 0", FETCH_RD); end
    n_cmp++; if (DEC_VALID !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid got %0b want 0", DEC_VALID); end
    n_cmp++; if (DEC_IR !== 32'h13) begin n_err++; $display("FAIL reset_dec_ir got %h want 00000013", DEC_IR); end
    n_cmp++; if (DEC_PC !== 32'h0) begin n_err++; $display("FAIL reset_dec_pc got %h want 0", DEC_PC); end
    n_cmp++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", COUNT); end
    tick;
    RST_N = 1'b1;
    #1;
  endtask

  task automatic test_first_fetch;
    n_cmp++; if (FETCH_RD !== 1'b1) begin n_err++; $display("FAIL first_rd got %0b want 1", FETCH_RD); end
    n_cmp++; if (FETCH_ADDR !== 32'h0) begin n_err++; $display("FAIL first_addr got %h want 0", FETCH_ADDR); end
    tick;
    n_cmp++; if (DEC_VALID !== 1'b0) begin n_err++; $display("FAIL first_c1_valid got %0b want 0", DEC_VALID); end
    n_cmp++; if (FETCH_ADDR !== 32'h4) begin n_err++; $display("FAIL first_c1_addr got %h want 4", FETCH_ADDR); end
    tick;
    n_cmp++; if (DEC_VALID !== 1'b1) begin n_err++; $display("FAIL first_c2_valid got %0b want 1", DEC_VALID); end
    n_cmp++; if (DEC_PC !== 32'h0) begin n_err++; $display("FAIL first_c2_pc got %h want 0", DEC_PC); end
    n_cmp++; if (DEC_IR !== 32'h5A5A_A5A5) begin n_err++; $display("FAIL first_c2_ir got %h want 5a5aa5a5", DEC_IR); end
    for (int i = 1; i <= 3; i++) begin
      tick;
      n_cmp++;
      if (DEC_VALID !== 1'b1 || DEC_PC !== 32'(4 * i)) begin
        n_err++; $display("FAIL first_stream valid=%0b pc=%h want pc %h", DEC_VALID, DEC_PC, 32'(4 * i));
      end
    end
    exp_pc = 32'hC;
  endtask

  task automatic test_backpressure;
    DEC_READY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      n_cmp++; if (COUNT > 3'd4) begin n_err++; $display("FAIL bp_count_bound got %0d want <=4", COUNT); end
    end
    n_cmp++; if (COUNT !== 3'd4) begin n_err++; $display("FAIL bp_count_sat got %0d want 4", COUNT); end
    n_cmp++; if (FETCH_RD !== 1'b0) begin n_err++; $display("FAIL bp_rd_stall got %0b want 0", FETCH_RD); end
    n_cmp++; if (DEC_PC !== exp_pc) begin n_err++; $display("FAIL bp_head got %h want %h", DEC_PC, exp_pc); end
    DEC_READY = 1'b1;
    #1;
    n_cmp++; if (FETCH_RD !== 1'b1) begin n_err++; $display("FAIL bp_rd_on_ready got %0b want 1", FETCH_RD); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (DEC_VALID !== 1'b1 || DEC_PC !== exp_pc || DEC_IR !== ir_of(exp_pc)) begin
        n_err++; $display("FAIL bp_drain valid=%0b pc=%h ir=%h want pc %h", DEC_VALID, DEC_PC, DEC_IR, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      tick;
    end
  endtask

  task automatic test_redirect_full;
    DEC_READY = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (COUNT == 3'd4) break;
      tick;
    end
    n_cmp++; if (COUNT !== 3'd4) begin n_err++; $display("FAIL rdf_fill got %0d want 4", COUNT); end
    DEC_READY = 1'b1;
    #1;
    exp_pc = exp_pc + 32'd4;
    tick;
    n_cmp++; if (COUNT !== 3'd3) begin n_err++; $display("FAIL rdf_pre_count got %0d want 3", COUNT); end
    n_cmp++; if (DEC_PC !== exp_pc) begin n_err++; $display("FAIL rdf_pre_head got %h want %h", DEC_PC, exp_pc); end
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100;
    #1;
    n_cmp++; if (FETCH_RD !== 1'b1) begin n_err++; $display("FAIL rdf_rd got %0b want 1", FETCH_RD); end
    n_cmp++; if (FETCH_ADDR !== 32'h100) begin n_err++; $display("FAIL rdf_addr got %h want 100", FETCH_ADDR); end
    tick;
    REDIRECT = 1'b0;
    #1;
    n_cmp++; if (DEC_VALID !== 1'b0) begin n_err++; $display("FAIL rdf_post_valid got %0b want 0", DEC_VALID); end
    n_cmp++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL rdf_post_count got %0d want 0", COUNT); end
    n_cmp++; if (FETCH_ADDR !== 32'h104) begin n_err++; $display("FAIL rdf_post_addr got %h want 104", FETCH_ADDR); end
    tick;
    exp_pc = 32'h100;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (DEC_VALID !== 1'b1 || DEC_PC !== exp_pc || DEC_IR !== ir_of(exp_pc)) begin
        n_err++; $display("FAIL rdf_stream valid=%0b pc=%h ir=%h want pc %h", DEC_VALID, DEC_PC, DEC_IR, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      tick;
    end
  endtask

  task automatic test_redirect_align_b2b;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h203;
    #1;
    n_cmp++; if (FETCH_ADDR !== 32'h200) begin n_err++; $display("FAIL align_addr got %h want 200", FETCH_ADDR); end
    tick;
    REDIRECT = 1'b0;
    #1;
    n_cmp++; if (DEC_VALID !== 1'b0) begin n_err++; $display("FAIL align_bubble got %0b want 0", DEC_VALID); end
    tick;
    n_cmp++; if (DEC_PC !== 32'h200 || DEC_IR !== ir_of(32'h200)) begin n_err++; $display("FAIL align_pc got %h/%h want 200", DEC_PC, DEC_IR); end
    tick;
    n_cmp++; if (DEC_PC !== 32'h204) begin n_err++; $display("FAIL align_next got %h want 204", DEC_PC); end
    REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
    #1;
    n_cmp++; if (FETCH_ADDR !== 32'h40) begin n_err++; $display("FAIL b2b_addr0 got %h want 40", FETCH_ADDR); end
    tick;
    REDIRECT_PC = 32'h80;
    #1;
    n_cmp++; if (FETCH_ADDR !== 32'h80) begin n_err++; $display("FAIL b2b_addr1 got %h want 80", FETCH_ADDR); end
    n_cmp++; if (DEC_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_mid_valid got %0b want 0", DEC_VALID); end
    tick;
    REDIRECT = 1'b0;
    #1;
    n_cmp++; if (DEC_VALID !== 1'b0 || COUNT !== 3'd0) begin n_err++; $display("FAIL b2b_post valid=%0b count=%0d want 0/0", DEC_VALID, COUNT); end
    tick;
    exp_pc = 32'h80;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (DEC_VALID !== 1'b1 || DEC_PC !== exp_pc) begin
        n_err++; $display("FAIL b2b_stream valid=%0b pc=%h want %h", DEC_VALID, DEC_PC, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      tick;
    end
  endtask

  task automatic test_toggle;
    logic rd_prev;
    logic pop_m;
    int   credit_m;
    int   delivered;
    delivered = 0;
    rd_prev = FETCH_RD;
    n_cmp++; if (DEC_PC !== exp_pc) begin n_err++; $display("FAIL tog_start got %h want %h", DEC_PC, exp_pc); end
    exp_pc = exp_pc + 32'd4;
    tick;
    for (int i = 0; i < 40; i++) begin
      DEC_READY = (i % 2 == 1);
      #1;
      pop_m    = DEC_VALID && DEC_READY;
      credit_m = int'(COUNT) + int'(rd_prev) - int'(pop_m);
      n_cmp++; if (COUNT > 3'd4) begin n_err++; $display("FAIL tog_count got %0d want <=4", COUNT); end
      n_cmp++;
      if (FETCH_RD !== (credit_m < DEPTH)) begin
        n_err++; $display("FAIL tog_issue rd=%0b credit=%0d", FETCH_RD, credit_m);
      end
      if (pop_m) begin
        n_cmp++;
        if (DEC_PC !== exp_pc || DEC_IR !== ir_of(exp_pc)) begin
          n_err++; $display("FAIL tog_order pc=%h ir=%h want pc %h", DEC_PC, DEC_IR, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      rd_prev = FETCH_RD;
      tick;
    end
    n_cmp++; if (delivered != 20) begin n_err++; $display("FAIL tog_delivered got %0d want 20", delivered); end
    DEC_READY = 1'b1;
  endtask

  task automatic test_reset_midstream;
    REDIRECT = 1'b1; REDIRECT_PC = 32'h300; DEC_READY = 1'b0;
    tick;
    REDIRECT = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (COUNT == 3'd3) break;
      tick;
    end
    n_cmp++; if (COUNT !== 3'd3) begin n_err++; $display("FAIL mr_fill got %0d want 3", COUNT); end
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++; if (DEC_VALID !== 1'b0) begin n_err++; $display("FAIL mr_valid got %0b want 0", DEC_VALID); end
    n_cmp++; if (DEC_IR !== 32'h13) begin n_err++; $display("FAIL mr_ir got %h want 00000013", DEC_IR); end
    n_cmp++; if (DEC_PC !== 32'h0) begin n_err++; $display("FAIL mr_pc got %h want 0", DEC_PC); end
    n_cmp++; if (COUNT !== 3'd0) begin n_err++; $display("FAIL mr_count got %0d want 0", COUNT); end
    n_cmp++; if (FETCH_RD !== 1'b0) begin n_err++; $display("FAIL mr_rd got %0b want 0", FETCH_RD); end
    tick; tick;
    RST_N = 1'b1; DEC_READY = 1'b1;
    #1;
    n_cmp++; if (FETCH_RD !== 1'b1 || FETCH_ADDR !== 32'h0) begin n_err++; $display("FAIL mr_restart rd=%0b addr=%h want 1/0", FETCH_RD, FETCH_ADDR); end
    tick; tick;
    n_cmp++; if (DEC_VALID !== 1'b1 || DEC_PC !== 32'h0) begin n_err++; $display("FAIL mr_first valid=%0b pc=%h want 1/0", DEC_VALID, DEC_PC); end
    tick;
    n_cmp++; if (DEC_PC !== 32'h4) begin n_err++; $display("FAIL mr_second got %h want 4", DEC_PC); end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_backpressure;
    test_redirect_full;
    test_redirect_align_b2b;
    test_toggle;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
